// File: rtl/fifo_burst_reader.sv
// ============================================================================
// Module   : fifo_burst_reader
// Purpose  : Fetches a burst of words from a synchronous FIFO and replays them
//            as a valid/ready stream with last-beat marking.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fifo_burst_reader #(
    parameter int WIDTH = 32,
    parameter int LEN_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [LEN_W-1:0] burst_len,
    output logic             busy,
    output logic             done,
    input  logic             fifo_empty,
    input  logic [WIDTH-1:0] fifo_data,
    output logic             fifo_cs,
    output logic             fifo_rd_en,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [WIDTH-1:0] m_data,
    output logic             m_last
);

    localparam logic [LEN_W-1:0] LEN_ONE = LEN_W'(1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_BURST = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [LEN_W-1:0] issued_q, issued_d;
    logic [LEN_W-1:0] delivered_q, delivered_d;
    logic [1:0]       occ_q, occ_d;
    logic             head_q, head_d;
    logic             pend_q, pend_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] buf_q [2];
    logic [WIDTH-1:0] buf_d [2];

    logic             pop;
    logic             rd;
    logic             tail;
    logic [2:0]       committed;
    logic [2:0]       capacity;

    assign m_valid    = (occ_q != 2'd0);
    assign pop        = m_valid & m_ready;
    assign m_data     = buf_q[head_q];
    assign m_last     = m_valid && (delivered_q == (len_q - LEN_ONE));
    assign busy       = (state_q != S_IDLE);
    assign fifo_cs    = busy;
    assign done       = done_q;

    // A read is only issued when the slot it will land in is already free,
    // counting the word still in flight from the previous cycle.
    assign committed  = {1'b0, occ_q} + {2'b00, pend_q};
    assign capacity   = 3'd2 + {2'b00, pop};
    assign rd         = (state_q == S_BURST) && !fifo_empty &&
                        (issued_q < len_q) && (committed < capacity);
    assign fifo_rd_en = rd;

    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        issued_d    = issued_q;
        delivered_d = delivered_q;
        head_d      = head_q;
        done_d      = 1'b0;
        pend_d      = rd;
        buf_d       = buf_q;
        tail        = head_q ^ occ_q[0];

        if (pend_q) begin
            buf_d[tail] = fifo_data;
        end
        occ_d = occ_q + {1'b0, pend_q} - {1'b0, pop};
        if (pop) begin
            head_d      = ~head_q;
            delivered_d = delivered_q + LEN_ONE;
        end
        if (rd) begin
            issued_d = issued_q + LEN_ONE;
        end

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (burst_len != '0) begin
                        len_d       = burst_len;
                        issued_d    = '0;
                        delivered_d = '0;
                        state_d     = S_BURST;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            S_BURST: begin
                if (rd && ((issued_q + LEN_ONE) == len_q)) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (pop && m_last) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            len_q       <= '0;
            issued_q    <= '0;
            delivered_q <= '0;
            occ_q       <= 2'd0;
            head_q      <= 1'b0;
            pend_q      <= 1'b0;
            done_q      <= 1'b0;
            buf_q[0]    <= '0;
            buf_q[1]    <= '0;
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            issued_q    <= issued_d;
            delivered_q <= delivered_d;
            occ_q       <= occ_d;
            head_q      <= head_d;
            pend_q      <= pend_d;
            done_q      <= done_d;
            buf_q[0]    <= buf_d[0];
            buf_q[1]    <= buf_d[1];
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_fifo_burst_reader.sv
// ============================================================================
// Module   : tb_fifo_burst_reader
// Purpose  : Self-checking bench for fifo_burst_reader with a FIFO model and
//            an in-order word scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fifo_burst_reader;

    localparam int WIDTH = 32;
    localparam int LEN_W = 8;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             start;
    logic [LEN_W-1:0] burst_len;
    logic             busy;
    logic             done;
    logic             fifo_empty;
    logic [WIDTH-1:0] fifo_data = '0;
    logic             fifo_cs;
    logic             fifo_rd_en;
    logic             m_valid;
    logic             m_ready;
    logic [WIDTH-1:0] m_data;
    logic             m_last;

    fifo_burst_reader #(.WIDTH(WIDTH), .LEN_W(LEN_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .burst_len  (burst_len),
        .busy       (busy),
        .done       (done),
        .fifo_empty (fifo_empty),
        .fifo_data  (fifo_data),
        .fifo_cs    (fifo_cs),
        .fifo_rd_en (fifo_rd_en),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_data     (m_data),
        .m_last     (m_last)
    );

    always #5 clk = ~clk;

    // FIFO model: every word ever written lives in stream[], in order.
    logic [WIDTH-1:0] stream [0:255];
    int pushed_n = 0;
    int popped_n = 0;

    assign fifo_empty = (pushed_n == popped_n);

    always @(posedge clk) begin
        if (fifo_cs && fifo_rd_en && (pushed_n != popped_n)) begin
            fifo_data <= stream[popped_n];
            popped_n  <= popped_n + 1;
        end
    end

    int tests = 0;
    int fails = 0;

    int mon_en     = 0;
    int mon_base   = 0;
    int mon_len    = 0;
    int mon_beat   = 0;
    logic             prev_stall = 1'b0;
    logic [WIDTH-1:0] prev_data  = '0;
    logic             prev_last  = 1'b0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic push_words(input int n);
        for (int i = 0; i < n; i++) begin
            stream[pushed_n] = $urandom;
            pushed_n++;
        end
    endtask

    // Scoreboard step, taken on the falling edge between active edges.
    task automatic monitor_step();
        int outst;
        outst = popped_n - mon_base - mon_beat;
        check("outstanding_le_2", 64'(outst <= 2), 64'd1);
        if (fifo_rd_en) check("rd_en_while_empty", 64'(fifo_empty), 64'd0);
        if (prev_stall) begin
            check("stall_valid", 64'(m_valid), 64'd1);
            check("stall_data", 64'(m_data), 64'(prev_data));
            check("stall_last", 64'(m_last), 64'(prev_last));
        end
        if (m_valid && m_ready) begin
            if (mon_beat < mon_len) begin
                check("beat_data", 64'(m_data), 64'(stream[mon_base + mon_beat]));
                check("beat_last", 64'(m_last), 64'(mon_beat == mon_len - 1));
            end else begin
                check("extra_beat", 64'(mon_beat), 64'(mon_len));
            end
            mon_beat++;
        end
        prev_stall = m_valid && !m_ready;
        prev_data  = m_data;
        prev_last  = m_last;
    endtask

    task automatic tick();
        @(negedge clk);
        if (mon_en != 0) monitor_step();
        @(posedge clk);
        #1;
    endtask

    task automatic arm_monitor(input int len);
        mon_base   = popped_n;
        mon_len    = len;
        mon_beat   = 0;
        prev_stall = 1'b0;
        mon_en     = 1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_busy"},    64'(busy),       64'd0);
        check({tag, "_done"},    64'(done),       64'd0);
        check({tag, "_cs"},      64'(fifo_cs),    64'd0);
        check({tag, "_rd_en"},   64'(fifo_rd_en), 64'd0);
        check({tag, "_m_valid"}, 64'(m_valid),    64'd0);
        check({tag, "_m_last"},  64'(m_last),     64'd0);
        check({tag, "_m_data"},  64'(m_data),     64'd0);
    endtask

    // mode: 0 ready always, 1 ready pattern 1,0,0, 2 random ready
    task automatic run_burst(input string tag, input int len, input int mode,
                             input int late_n, input int late_at, input int ign_at);
        logic seen;
        seen = 1'b0;
        arm_monitor(len);
        start     = 1'b1;
        burst_len = LEN_W'(len);
        m_ready   = (mode == 2) ? 1'($urandom_range(0, 1)) : 1'b1;
        for (int cyc = 1; cyc <= 600; cyc++) begin
            tick();
            start = (cyc == ign_at);
            if (cyc == ign_at) burst_len = LEN_W'(3);
            case (mode)
                1:       m_ready = (cyc % 3 == 0);
                2:       m_ready = 1'($urandom_range(0, 1));
                default: m_ready = 1'b1;
            endcase
            if (cyc == late_at) push_words(late_n);
            if (done) begin
                seen = 1'b1;
                break;
            end
        end
        check({tag, "_done_seen"}, 64'(seen), 64'd1);
        check({tag, "_beats"}, 64'(mon_beat), 64'(len));
        check({tag, "_reads"}, 64'(popped_n - mon_base), 64'(len));
        check({tag, "_busy_at_done"}, 64'(busy), 64'd0);
        start   = 1'b0;
        m_ready = 1'b1;
        tick();
        check({tag, "_done_one_cycle"}, 64'(done), 64'd0);
    endtask

    initial begin
        logic seen;
        rst_n     = 1'b0;
        start     = 1'b0;
        burst_len = '0;
        m_ready   = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        rst_n = 1'b1;
        tick();

        // Basic cycle-exact burst of 4.
        push_words(4);
        m_ready   = 1'b1;
        arm_monitor(4);
        start     = 1'b1;
        burst_len = LEN_W'(4);
        tick();
        start = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            check($sformatf("basic_rd_en_c%0d", c),   64'(fifo_rd_en), 64'(c >= 1 && c <= 4));
            check($sformatf("basic_m_valid_c%0d", c), 64'(m_valid),    64'(c >= 3 && c <= 6));
            check($sformatf("basic_m_last_c%0d", c),  64'(m_last),     64'(c == 6));
            check($sformatf("basic_done_c%0d", c),    64'(done),       64'(c == 7));
            check($sformatf("basic_busy_c%0d", c),    64'(busy),       64'(c <= 6));
            tick();
        end
        check("basic_beats", 64'(mon_beat), 64'd4);

        // Backpressure; two words must stay behind in the FIFO.
        push_words(8);
        run_burst("bp", 6, 1, 0, 0, 0);
        check("bp_fifo_left", 64'(pushed_n - popped_n), 64'd2);
        run_burst("bp_rest", 2, 0, 0, 0, 0);

        // FIFO runs dry mid-burst.
        push_words(2);
        run_burst("underflow", 5, 0, 3, 10, 0);

        // Zero-length request with data waiting in the FIFO.
        push_words(2);
        mon_en    = 0;
        start     = 1'b1;
        burst_len = '0;
        tick();
        start = 1'b0;
        check("zero_done",    64'(done),       64'd1);
        check("zero_busy",    64'(busy),       64'd0);
        check("zero_rd_en",   64'(fifo_rd_en), 64'd0);
        check("zero_m_valid", 64'(m_valid),    64'd0);
        tick();
        check("zero_done_clear", 64'(done),    64'd0);
        check("zero_no_reads", 64'(pushed_n - popped_n), 64'd2);

        // Start while busy is ignored.
        push_words(3);
        run_burst("ignore", 5, 0, 0, 0, 3);
        tick();
        check("ignore_stays_idle", 64'(busy), 64'd0);
        check("ignore_fifo_left", 64'(pushed_n - popped_n), 64'd0);

        // Randomized lengths and backpressure.
        for (int i = 0; i < 4; i++) begin
            int len;
            len = $urandom_range(1, 12);
            push_words(len + $urandom_range(0, 2));
            run_burst($sformatf("rand%0d", i), len, 2, 0, 0, 0);
            mon_en = 0;
            while (pushed_n != popped_n) begin
                run_burst($sformatf("rand%0d_flush", i), pushed_n - popped_n, 0, 0, 0, 0);
            end
        end

        // Reset mid-burst after two delivered beats.
        push_words(8);
        arm_monitor(8);
        m_ready   = 1'b1;
        start     = 1'b1;
        burst_len = LEN_W'(8);
        seen      = 1'b0;
        for (int cyc = 0; cyc < 40; cyc++) begin
            tick();
            start = 1'b0;
            if (mon_beat >= 2) begin
                seen = 1'b1;
                break;
            end
        end
        check("rst_two_beats_seen", 64'(seen), 64'd1);
        mon_en = 0;
        rst_n  = 1'b0;
        #1;
        check_reset_outputs("midrst");
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        push_words(2);
        run_burst("after_rst", 2, 0, 0, 0, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
